// File: rtl/id_stage_pipe_pkg.sv
// id_stage_pipe_pkg
// Purpose: shared definitions for the ID stage. Contains the default datapath
//          width, opcode and funct codes, ALU control encodings, branch-condition
//          and forward-select encodings, the decoded control bundle with its NOP
//          value, and the control decoder function.
// Ports:   none (package).
// Config:  nothing in this file depends on ID_PERF_CNT_EN.
package id_stage_pipe_pkg;

  localparam int WIDTH_DEF = 32;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  typedef enum logic {BR_EQ = 1'b0, BR_NE = 1'b1} brcond_e;

  typedef enum logic [1:0] {FWD_RF = 2'd0, FWD_WB = 2'd1, FWD_MEM = 2'd2} fwd_e;

  typedef struct packed {
    logic       regwrite;
    logic       memtoreg;
    logic       memwrite;
    logic       alusrc;
    logic       regdst;
    logic       branch;
    logic       jump;
    brcond_e    brcond;
    logic       use_rs;
    logic       use_rt;
    logic [3:0] alucontrol;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

  function automatic ctrl_t decode_ctrl(input logic [5:0] op, input logic [5:0] funct);
    ctrl_t c;
    c = CTRL_NOP;
    case (op)
      OP_RTYPE: begin
        c.regwrite = 1'b1;
        c.regdst   = 1'b1;
        c.use_rs   = 1'b1;
        c.use_rt   = 1'b1;
        case (funct)
          FN_ADD:  c.alucontrol = ALU_ADD;
          FN_SUB:  c.alucontrol = ALU_SUB;
          FN_AND:  c.alucontrol = ALU_AND;
          FN_OR:   c.alucontrol = ALU_OR;
          FN_SLT:  c.alucontrol = ALU_SLT;
          default: c.alucontrol = ALU_AND;
        endcase
      end
      OP_LW: begin
        c.regwrite   = 1'b1;
        c.memtoreg   = 1'b1;
        c.alusrc     = 1'b1;
        c.use_rs     = 1'b1;
        c.alucontrol = ALU_ADD;
      end
      OP_SW: begin
        c.memwrite   = 1'b1;
        c.alusrc     = 1'b1;
        c.use_rs     = 1'b1;
        c.use_rt     = 1'b1;
        c.alucontrol = ALU_ADD;
      end
      OP_ADDI: begin
        c.regwrite   = 1'b1;
        c.alusrc     = 1'b1;
        c.use_rs     = 1'b1;
        c.alucontrol = ALU_ADD;
      end
      OP_BEQ, OP_BNE: begin
        c.branch     = 1'b1;
        c.brcond     = (op == OP_BNE) ? BR_NE : BR_EQ;
        c.use_rs     = 1'b1;
        c.use_rt     = 1'b1;
        c.alucontrol = ALU_SUB;
      end
      OP_J: c.jump = 1'b1;
      default: c = CTRL_NOP;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/id_stage_pipe_hazard_unit.sv
// id_hazard_unit
// Purpose: combinational hazard detection and branch-operand forward selection
//          for the ID stage.
// Ports:
//   valid, use_rs, use_rt, branch     : decoded facts about the ID instruction
//   rs, rt                            : source register fields
//   regwrite_ex, memtoreg_ex, regaddr_ex    : EX-stage producer
//   regwrite_mem, memtoreg_mem, regaddr_mem : MEM-stage producer
//   regwrite_wb, regaddr_wb           : WB-stage producer
//   hazard                            : stall ID and insert a bubble into ID/EX
//   sel_a, sel_b                      : operand source for rs / rt
// Config:  nothing in this file depends on ID_PERF_CNT_EN.
module id_hazard_unit
  import id_stage_pipe_pkg::*;
#(
  parameter int RA_W = 5
) (
  input  logic            valid,
  input  logic            use_rs,
  input  logic            use_rt,
  input  logic            branch,
  input  logic [RA_W-1:0] rs,
  input  logic [RA_W-1:0] rt,
  input  logic            regwrite_ex,
  input  logic            memtoreg_ex,
  input  logic [RA_W-1:0] regaddr_ex,
  input  logic            regwrite_mem,
  input  logic            memtoreg_mem,
  input  logic [RA_W-1:0] regaddr_mem,
  input  logic            regwrite_wb,
  input  logic [RA_W-1:0] regaddr_wb,
  output logic            hazard,
  output fwd_e            sel_a,
  output fwd_e            sel_b
);

  logic live_a, live_b;
  logic ex_hit, mem_hit;

  // A source only matters when it is actually read and is not r0.
  assign live_a = valid & use_rs & (rs != '0);
  assign live_b = valid & use_rt & (rt != '0);

  assign ex_hit  = (live_a & (regaddr_ex == rs))  | (live_b & (regaddr_ex == rt));
  assign mem_hit = (live_a & (regaddr_mem == rs)) | (live_b & (regaddr_mem == rt));

  // A load in EX stalls everyone; branches resolve in ID and so also wait for
  // ALU results still in EX and for load data still in MEM.
  assign hazard = (memtoreg_ex & ex_hit)
                | (branch & regwrite_ex & ex_hit)
                | (branch & memtoreg_mem & mem_hit);

  function automatic fwd_e pick(input logic [RA_W-1:0] src,
                                input logic rw_mem, input logic m2r_mem,
                                input logic [RA_W-1:0] a_mem,
                                input logic rw_wb, input logic [RA_W-1:0] a_wb);
    if (src != '0 && rw_mem && !m2r_mem && a_mem == src) return FWD_MEM;
    if (src != '0 && rw_wb && a_wb == src)               return FWD_WB;
    return FWD_RF;
  endfunction

  always_comb begin
    sel_a = pick(rs, regwrite_mem, memtoreg_mem, regaddr_mem, regwrite_wb, regaddr_wb);
    sel_b = pick(rt, regwrite_mem, memtoreg_mem, regaddr_mem, regwrite_wb, regaddr_wb);
  end

endmodule

// File: rtl/id_stage_pipe.sv
// id_stage_pipe
// Purpose: ID stage. Decodes the IF/ID instruction, reads the register file
//          (with WB bypass and MEM forwarding), resolves branches/jumps, detects
//          hazards, and owns the ID/EX pipeline register.
// Ports:
//   clk, rst (async, active-low)
//   instr_decode, pc_decode, valid_decode  : IF/ID contents
//   hold_ex                                : downstream stall, freezes ID/EX
//   *_ex / *_mem / *_wb inputs             : later-stage producers
//   stall_decode, flush_fetch, pc_target   : fetch control
//   valid_ex and *_ex_o                    : ID/EX register contents
//   stall_cnt, flush_cnt                   : only when ID_PERF_CNT_EN is defined
// Config:  `define ID_PERF_CNT_EN adds saturating stall/flush counters.
module id_stage_pipe
  import id_stage_pipe_pkg::*;
#(
  parameter int WIDTH    = WIDTH_DEF,
  parameter int RA_W     = 5,
  parameter int NUM_REGS = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      instr_decode,
  input  logic [WIDTH-1:0] pc_decode,
  input  logic             valid_decode,
  input  logic             hold_ex,
  input  logic             regwrite_ex,
  input  logic             memtoreg_ex,
  input  logic [RA_W-1:0]  regaddr_ex,
  input  logic             regwrite_mem,
  input  logic             memtoreg_mem,
  input  logic [RA_W-1:0]  regaddr_mem,
  input  logic [WIDTH-1:0] aluout_mem,
  input  logic             regwrite_wb,
  input  logic [RA_W-1:0]  regaddr_wb,
  input  logic [WIDTH-1:0] result_wb,
  output logic             stall_decode,
  output logic             flush_fetch,
  output logic [WIDTH-1:0] pc_target,
  output logic             valid_ex,
  output logic             regwrite_ex_o,
  output logic             memtoreg_ex_o,
  output logic             memwrite_ex_o,
  output logic             alusrc_ex_o,
  output logic             regdst_ex_o,
  output logic [3:0]       alucontrol_ex_o,
  output logic [WIDTH-1:0] data1_ex_o,
  output logic [WIDTH-1:0] data2_ex_o,
  output logic [WIDTH-1:0] signext_ex_o,
  output logic [RA_W-1:0]  rs_ex_o,
  output logic [RA_W-1:0]  rt_ex_o,
  output logic [RA_W-1:0]  rd_ex_o
`ifdef ID_PERF_CNT_EN
  ,
  output logic [15:0]      stall_cnt,
  output logic [15:0]      flush_cnt
`endif
);

  ctrl_t            ctrl;
  logic [RA_W-1:0]  rs, rt, rd;
  logic [WIDTH-1:0] signext, br_target, j_target;
  logic [WIDTH-1:0] rf [NUM_REGS];
  logic [WIDTH-1:0] rf_a, rf_b, op_a, op_b;
  logic             rf_we, hazard, taken;
  fwd_e             sel_a, sel_b;

  assign ctrl    = decode_ctrl(instr_decode[31:26], instr_decode[5:0]);
  assign rs      = RA_W'(instr_decode[25:21]);
  assign rt      = RA_W'(instr_decode[20:16]);
  assign rd      = RA_W'(instr_decode[15:11]);
  assign signext = {{(WIDTH-16){instr_decode[15]}}, instr_decode[15:0]};

  function automatic logic in_range(input logic [RA_W-1:0] a);
    return ({1'b0, a} < (RA_W+1)'(NUM_REGS));
  endfunction

  // Register file: r0 and unimplemented addresses read zero and ignore writes.
  assign rf_we = regwrite_wb & (regaddr_wb != '0) & in_range(regaddr_wb);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) rf[i] <= '0;
    end else if (rf_we) begin
      rf[regaddr_wb] <= result_wb;
    end
  end

  always_comb begin
    rf_a = '0;
    rf_b = '0;
    if (rs != '0 && in_range(rs)) rf_a = rf[rs];
    if (rt != '0 && in_range(rt)) rf_b = rf[rt];
  end

  id_hazard_unit #(.RA_W(RA_W)) u_hazard (
    .valid        (valid_decode),
    .use_rs       (ctrl.use_rs),
    .use_rt       (ctrl.use_rt),
    .branch       (ctrl.branch),
    .rs           (rs),
    .rt           (rt),
    .regwrite_ex  (regwrite_ex),
    .memtoreg_ex  (memtoreg_ex),
    .regaddr_ex   (regaddr_ex),
    .regwrite_mem (regwrite_mem),
    .memtoreg_mem (memtoreg_mem),
    .regaddr_mem  (regaddr_mem),
    .regwrite_wb  (regwrite_wb),
    .regaddr_wb   (regaddr_wb),
    .hazard       (hazard),
    .sel_a        (sel_a),
    .sel_b        (sel_b)
  );

  always_comb begin
    case (sel_a)
      FWD_MEM: op_a = aluout_mem;
      FWD_WB:  op_a = result_wb;
      default: op_a = rf_a;
    endcase
    case (sel_b)
      FWD_MEM: op_b = aluout_mem;
      FWD_WB:  op_b = result_wb;
      default: op_b = rf_b;
    endcase
  end

  assign taken     = ctrl.branch & ((ctrl.brcond == BR_NE) ? (op_a != op_b) : (op_a == op_b));
  assign br_target = pc_decode + (signext << 2);
  assign j_target  = {pc_decode[WIDTH-1:28], instr_decode[25:0], 2'b00};
  assign pc_target = ctrl.jump ? j_target : br_target;

  // hold_ex folds into stall so a branch that cannot advance never redirects;
  // it re-resolves once the hold drops.
  assign stall_decode = hazard | hold_ex;
  assign flush_fetch  = valid_decode & ~stall_decode & (ctrl.jump | taken);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_ex        <= 1'b0;
      regwrite_ex_o   <= 1'b0;
      memtoreg_ex_o   <= 1'b0;
      memwrite_ex_o   <= 1'b0;
      alusrc_ex_o     <= 1'b0;
      regdst_ex_o     <= 1'b0;
      alucontrol_ex_o <= '0;
      data1_ex_o      <= '0;
      data2_ex_o      <= '0;
      signext_ex_o    <= '0;
      rs_ex_o         <= '0;
      rt_ex_o         <= '0;
      rd_ex_o         <= '0;
    end else if (!hold_ex) begin
      if (hazard || !valid_decode) begin
        valid_ex        <= 1'b0;
        regwrite_ex_o   <= 1'b0;
        memtoreg_ex_o   <= 1'b0;
        memwrite_ex_o   <= 1'b0;
        alusrc_ex_o     <= 1'b0;
        regdst_ex_o     <= 1'b0;
        alucontrol_ex_o <= '0;
        data1_ex_o      <= '0;
        data2_ex_o      <= '0;
        signext_ex_o    <= '0;
        rs_ex_o         <= '0;
        rt_ex_o         <= '0;
        rd_ex_o         <= '0;
      end else begin
        valid_ex        <= 1'b1;
        regwrite_ex_o   <= ctrl.regwrite;
        memtoreg_ex_o   <= ctrl.memtoreg;
        memwrite_ex_o   <= ctrl.memwrite;
        alusrc_ex_o     <= ctrl.alusrc;
        regdst_ex_o     <= ctrl.regdst;
        alucontrol_ex_o <= ctrl.alucontrol;
        data1_ex_o      <= op_a;
        data2_ex_o      <= op_b;
        signext_ex_o    <= signext;
        rs_ex_o         <= rs;
        rt_ex_o         <= rt;
        rd_ex_o         <= rd;
      end
    end
  end

`ifdef ID_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (hazard && stall_cnt != 16'hFFFF)      stall_cnt <= stall_cnt + 16'd1;
      if (flush_fetch && flush_cnt != 16'hFFFF) flush_cnt <= flush_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_id_stage_pipe.sv
module tb_id_stage_pipe;

  localparam int WIDTH = 32;
  localparam int RA_W  = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic [31:0]      instr_decode;
  logic [WIDTH-1:0] pc_decode;
  logic             valid_decode, hold_ex;
  logic             regwrite_ex, memtoreg_ex;
  logic [RA_W-1:0]  regaddr_ex;
  logic             regwrite_mem, memtoreg_mem;
  logic [RA_W-1:0]  regaddr_mem;
  logic [WIDTH-1:0] aluout_mem;
  logic             regwrite_wb;
  logic [RA_W-1:0]  regaddr_wb;
  logic [WIDTH-1:0] result_wb;
  logic             stall_decode, flush_fetch;
  logic [WIDTH-1:0] pc_target;
  logic             valid_ex, regwrite_ex_o, memtoreg_ex_o, memwrite_ex_o, alusrc_ex_o, regdst_ex_o;
  logic [3:0]       alucontrol_ex_o;
  logic [WIDTH-1:0] data1_ex_o, data2_ex_o, signext_ex_o;
  logic [RA_W-1:0]  rs_ex_o, rt_ex_o, rd_ex_o;
`ifdef ID_PERF_CNT_EN
  logic [15:0]      stall_cnt, flush_cnt;
`endif

  int total  = 0;
  int passed = 0;

  // Hand-assembled instructions
  localparam logic [31:0] I_ADD_3_1_2 = 32'h0022_1820; // ADD r3,r1,r2
  localparam logic [31:0] I_ADD_6_5_1 = 32'h00A1_3020; // ADD r6,r5,r1
  localparam logic [31:0] I_BEQ_1_2_4 = 32'h1022_0004; // BEQ r1,r2,+4
  localparam logic [31:0] I_BNE_4_0_8 = 32'h1480_0008; // BNE r4,r0,+8
  localparam logic [31:0] I_J         = 32'h0804_0000; // J 0x0040000
  localparam logic [31:0] I_LW_5_m4_1 = 32'h8C25_FFFC; // LW r5,-4(r1)
  localparam logic [31:0] I_ADD_7_0_0 = 32'h0000_3820; // ADD r7,r0,r0
  localparam logic [31:0] I_SW_2_8_1  = 32'hAC22_0008; // SW r2,8(r1)

  always #5 clk = ~clk;

  id_stage_pipe #(.WIDTH(WIDTH), .RA_W(RA_W), .NUM_REGS(32)) dut (
    .clk(clk), .rst(rst),
    .instr_decode(instr_decode), .pc_decode(pc_decode), .valid_decode(valid_decode),
    .hold_ex(hold_ex),
    .regwrite_ex(regwrite_ex), .memtoreg_ex(memtoreg_ex), .regaddr_ex(regaddr_ex),
    .regwrite_mem(regwrite_mem), .memtoreg_mem(memtoreg_mem), .regaddr_mem(regaddr_mem),
    .aluout_mem(aluout_mem),
    .regwrite_wb(regwrite_wb), .regaddr_wb(regaddr_wb), .result_wb(result_wb),
    .stall_decode(stall_decode), .flush_fetch(flush_fetch), .pc_target(pc_target),
    .valid_ex(valid_ex), .regwrite_ex_o(regwrite_ex_o), .memtoreg_ex_o(memtoreg_ex_o),
    .memwrite_ex_o(memwrite_ex_o), .alusrc_ex_o(alusrc_ex_o), .regdst_ex_o(regdst_ex_o),
    .alucontrol_ex_o(alucontrol_ex_o),
    .data1_ex_o(data1_ex_o), .data2_ex_o(data2_ex_o), .signext_ex_o(signext_ex_o),
    .rs_ex_o(rs_ex_o), .rt_ex_o(rt_ex_o), .rd_ex_o(rd_ex_o)
`ifdef ID_PERF_CNT_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_pipe();
    regwrite_ex = 0; memtoreg_ex = 0; regaddr_ex = '0;
    regwrite_mem = 0; memtoreg_mem = 0; regaddr_mem = '0; aluout_mem = '0;
    regwrite_wb = 0; regaddr_wb = '0; result_wb = '0;
  endtask

  initial begin
    rst = 0; instr_decode = '0; pc_decode = '0; valid_decode = 0; hold_ex = 0;
    clear_pipe();
    #3;
    chk("rst_valid_ex", valid_ex, 0);
    chk("rst_regwrite", regwrite_ex_o, 0);
    chk("rst_data1", data1_ex_o, 0);
    chk("rst_stall", stall_decode, 0);
    chk("rst_flush", flush_fetch, 0);

    // ADD with WB bypass of r1
    rst = 1; instr_decode = I_ADD_3_1_2; valid_decode = 1;
    regwrite_wb = 1; regaddr_wb = 5'd1; result_wb = 32'd7;
    tick();
    chk("add_valid", valid_ex, 1);
    chk("add_data1_bypass", data1_ex_o, 32'd7);
    chk("add_rd", rd_ex_o, 5'd3);
    chk("add_rs", rs_ex_o, 5'd1);
    chk("add_rt", rt_ex_o, 5'd2);
    chk("add_aluctl", alucontrol_ex_o, 4'b0010);
    chk("add_regdst", regdst_ex_o, 1);
    chk("add_regwrite", regwrite_ex_o, 1);
    chk("add_alusrc", alusrc_ex_o, 0);

    // Reset mid-run, no clock edge
    #2; rst = 0; #1;
    chk("midrst_valid", valid_ex, 0);
    chk("midrst_data1", data1_ex_o, 0);
    chk("midrst_rd", rd_ex_o, 0);
    chk("midrst_regwrite", regwrite_ex_o, 0);
    rst = 1; regwrite_wb = 0;
    tick();
    chk("postrst_valid", valid_ex, 1);
    chk("postrst_rf_cleared", data1_ex_o, 0);

    // Write r1=7, no valid instruction -> bubble
    regwrite_wb = 1; regaddr_wb = 5'd1; result_wb = 32'd7; valid_decode = 0;
    tick();
    chk("bubble_valid", valid_ex, 0);
    chk("bubble_regdst", regdst_ex_o, 0);
    regwrite_wb = 0;

    // Load-use
    regwrite_ex = 1; memtoreg_ex = 1; regaddr_ex = 5'd5;
    instr_decode = I_ADD_6_5_1; valid_decode = 1; #1;
    chk("lu_stall", stall_decode, 1);
    chk("lu_flush", flush_fetch, 0);
    tick();
    chk("lu_bubble_valid", valid_ex, 0);
    chk("lu_bubble_rd", rd_ex_o, 0);
    regwrite_ex = 0; memtoreg_ex = 0;
    regwrite_mem = 1; memtoreg_mem = 1; regaddr_mem = 5'd5; #1;
    chk("lu_release", stall_decode, 0);
    tick();
    chk("lu_issue_valid", valid_ex, 1);
    chk("lu_issue_rs", rs_ex_o, 5'd5);
    chk("lu_issue_rd", rd_ex_o, 5'd6);
    chk("lu_issue_data2", data2_ex_o, 32'd7);
    clear_pipe();

    // Branch forwarding from MEM
    instr_decode = I_BEQ_1_2_4; pc_decode = 32'h100;
    regwrite_mem = 1; memtoreg_mem = 0; regaddr_mem = 5'd2; aluout_mem = 32'd8; #1;
    chk("beq_not_taken", flush_fetch, 0);
    aluout_mem = 32'd7; #1;
    chk("beq_taken", flush_fetch, 1);
    chk("beq_target", pc_target, 32'h110);
    chk("beq_stall", stall_decode, 0);
    tick();
    chk("beq_valid", valid_ex, 1);
    chk("beq_data2_fwd", data2_ex_o, 32'd7);
    chk("beq_aluctl", alucontrol_ex_o, 4'b0110);
    chk("beq_signext", signext_ex_o, 32'd4);
    chk("beq_regwrite", regwrite_ex_o, 0);
    clear_pipe();

    // Branch after load: two stalls, then WB bypass
    instr_decode = I_BNE_4_0_8; pc_decode = 32'h200;
    regwrite_ex = 1; memtoreg_ex = 1; regaddr_ex = 5'd4; #1;
    chk("bl_stall1", stall_decode, 1);
    chk("bl_flush1", flush_fetch, 0);
    tick();
    chk("bl_bubble1", valid_ex, 0);
    regwrite_ex = 0; memtoreg_ex = 0;
    regwrite_mem = 1; memtoreg_mem = 1; regaddr_mem = 5'd4; #1;
    chk("bl_stall2", stall_decode, 1);
    tick();
    chk("bl_bubble2", valid_ex, 0);
    clear_pipe();
    regwrite_wb = 1; regaddr_wb = 5'd4; result_wb = 32'd5; #1;
    chk("bl_stall_off", stall_decode, 0);
    chk("bl_flush", flush_fetch, 1);
    chk("bl_target", pc_target, 32'h220);
    tick();
    chk("bl_valid", valid_ex, 1);
    chk("bl_data1_wb", data1_ex_o, 32'd5);
    regwrite_wb = 0;

    // Jump under hold_ex, then released
    instr_decode = I_J; pc_decode = 32'h8000_0010; hold_ex = 1; #1;
    chk("j_hold_flush", flush_fetch, 0);
    chk("j_hold_stall", stall_decode, 1);
    chk("j_target", pc_target, 32'h8010_0000);
    tick();
    chk("hold_valid", valid_ex, 1);
    chk("hold_data1", data1_ex_o, 32'd5);
    chk("hold_aluctl", alucontrol_ex_o, 4'b0110);
    chk("hold_signext", signext_ex_o, 32'd8);
    hold_ex = 0; valid_decode = 0; #1;
    chk("j_invalid_flush", flush_fetch, 0);
    valid_decode = 1; #1;
    chk("j_flush", flush_fetch, 1);
    chk("j_target2", pc_target, 32'h8010_0000);
    tick();
    chk("j_valid", valid_ex, 1);
    chk("j_aluctl", alucontrol_ex_o, 4'b0000);
    chk("j_regwrite", regwrite_ex_o, 0);

    // LW with negative offset
    instr_decode = I_LW_5_m4_1;
    tick();
    chk("lw_signext", signext_ex_o, 32'hFFFF_FFFC);
    chk("lw_memtoreg", memtoreg_ex_o, 1);
    chk("lw_alusrc", alusrc_ex_o, 1);
    chk("lw_regdst", regdst_ex_o, 0);
    chk("lw_rt", rt_ex_o, 5'd5);
    chk("lw_data1", data1_ex_o, 32'd7);

    // SW
    instr_decode = I_SW_2_8_1;
    tick();
    chk("sw_memwrite", memwrite_ex_o, 1);
    chk("sw_regwrite", regwrite_ex_o, 0);

    // r0 stays zero
    instr_decode = I_ADD_7_0_0;
    regwrite_wb = 1; regaddr_wb = 5'd0; result_wb = 32'hFFFF;
    tick();
    chk("r0_bypass_data1", data1_ex_o, 0);
    chk("r0_bypass_data2", data2_ex_o, 0);
    chk("r0_rd", rd_ex_o, 5'd7);
    regwrite_wb = 0;
    tick();
    chk("r0_read", data1_ex_o, 0);

`ifdef ID_PERF_CNT_EN
    chk("perf_stall_cnt", stall_cnt, 16'd3);
    chk("perf_flush_cnt", flush_cnt, 16'd3);
    instr_decode = I_ADD_6_5_1;
    regwrite_ex = 1; memtoreg_ex = 1; regaddr_ex = 5'd5;
    for (int i = 0; i < 70000; i++) tick();
    chk("perf_stall_sat", stall_cnt, 16'hFFFF);
    chk("perf_flush_hold", flush_cnt, 16'd3);
    clear_pipe();
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
